ws2812b_rx: RTL and testbench
=============================

# ws2812b_rx

Single-wire WS2812B stream decoder; the receive-side counterpart of the team's WS2812B driver. Samples the NRZ data line, classifies each high pulse as a 0 or 1 by width, assembles 24-bit GRB/RGB words MSB-first and presents them as pixels. Detects the latch (reset) gap as end-of-frame. Used as a bench/loopback monitor for LED strips and as a capture front-end for daisy-chained controllers.

## Interface

Parameters:
- FCLK, 100, clock frequency in MHz; TCLK = 1000/FCLK ns (integer division).
- NB_LEDS, 5, number of pixels per frame that are reported on the pixel port.
- TMIN, 150, ns; shortest legal high pulse. CMIN = TMIN/TCLK.
- TTHR, 625, ns; 0/1 threshold. CTHR = TTHR/TCLK.
- TMAX, 1200, ns; longest legal high pulse. CMAX = TMAX/TCLK.
- TRST, 50000, ns; low time that ends a frame. CRST = TRST/TCLK.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- din  input  1  WS2812B data line, asynchronous to clk.
- pixel  output  24  last decoded word, first received bit in [23].
- pixel_idx  output  32  index of pixel within frame, from 0.
- pixel_valid  output  1  one-cycle strobe; pixel/pixel_idx valid.
- frame_done  output  1  one-cycle strobe at end-of-frame.
- nb_pixels  output  32  complete pixels decoded in the frame just ended; valid with frame_done, held after.
- bit_err  output  1  one-cycle strobe on protocol error.
- busy  output  1  high while a frame is being received.

## Operation

- din passes through a 2-flop synchronizer (din_s), plus one delay flop (din_d) for edge detection. Rise: din_s & ~din_d; fall: ~din_s & din_d.
- Counter cnt, width $clog2(CRST)+1, saturates at CRST; cleared on every detected edge.
- States:
  - SYNC: entered from reset and after any high-pulse error. Counts consecutive low cycles; any high clears cnt. cnt reaching CRST -> IDLE. No strobes.
  - IDLE: line low, waiting. Rise -> HIGH, busy<=1, bit count 0, pixel count 0.
  - HIGH: counting. Fall with cnt < CMIN or cnt >= CMAX reached while high -> bit_err strobe, busy<=0, -> SYNC. Fall with CMIN <= cnt < CTHR shifts 0; CTHR <= cnt < CMAX shifts 1; -> LOW.
  - LOW: rise -> HIGH. cnt reaching CRST -> end-of-frame, -> IDLE.
- Bit assembly: shift left into 24-bit register, new bit at [0]. 24th bit: pixel<=word, pixel_idx<=pixel count, pixel_valid strobes only if pixel count < NB_LEDS; pixel count increments regardless (wraps at 2^32, not checked), bit count returns to 0.
- End-of-frame: frame_done strobe, nb_pixels<=pixel count, busy<=0. If bit count != 0 (partial word), bit_err strobes in the same cycle and the partial word is discarded.
- Rise and fall in the same cycle are impossible after synchronization; a high pulse of a single synchronized cycle is < CMIN for all legal parameters and errors.

## Timing

- Reset values: pixel 0, pixel_idx 0, pixel_valid 0, frame_done 0, nb_pixels 0, bit_err 0, busy 0, state SYNC, synchronizer flops 0.
- rst assertion clears all state immediately (mid-frame included); after release the block ignores din until CRST low cycles are seen.
- Latency: pixel_valid/bit_err (pulse error) high in the 3rd clk cycle after the first clk edge that samples din low on the deciding fall.
- frame_done asserts on the cycle cnt reaches CRST, i.e. CRST+3 cycles after din falls (±1 for sampling).
- All outputs registered; strobes exactly one cycle; pixel, pixel_idx, nb_pixels hold until next update.
- High width measured = synchronized width ±1 cycle; thresholds compare with <, boundaries exact per cnt.

## Test plan

- Reset, din low 5000 cycles, one pixel 0xFF0000 (0: 40 high/85 low, 1: 85 high/40 low), din low 5000 -> one pixel_valid, pixel=FF0000, pixel_idx=0; frame_done, nb_pixels=1, bit_err never.
- Frame FF0000,00FF00,FFFFFF,00FF00,00FF00 -> five strobes, idx 0..4, matching words; nb_pixels=5; busy high from first rise to frame_done.
- Seven pixels, NB_LEDS=5 -> five pixel_valid strobes (idx 0..4), nb_pixels=7.
- High widths 61 and 62 cycles -> bits 0 and 1; 14-cycle high -> bit_err, no pixel, subsequent bits ignored until 5000-cycle low, next frame decodes normally; 120-cycle high -> bit_err at cnt=120 while din still high.
- 12 bits then 5000-cycle low -> frame_done with bit_err same cycle, nb_pixels=0, no pixel_valid.
- rst low mid-pixel -> all outputs 0 asynchronously; release then start data with no preceding gap -> no strobes until 5000 low cycles, then next frame decodes.

Source files
------------

// File: rtl/ws2812b_rx.sv
// WS2812B single-wire decoder: classifies high pulses by width, emits 24-bit pixels MSB-first, flags latch gap as end-of-frame.
// Latency: pixel_valid/bit_err 3 cycles after din low is first sampled; frame_done CRST+3 cycles after the final fall.
// Backpressure: none; the line cannot be stalled, so every strobe is a single-cycle, fire-and-forget event.
module ws2812b_rx #(
    parameter int FCLK    = 100,
    parameter int NB_LEDS = 5,
    parameter int TMIN    = 150,
    parameter int TTHR    = 625,
    parameter int TMAX    = 1200,
    parameter int TRST    = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [23:0] pixel,
    output logic [31:0] pixel_idx,
    output logic        pixel_valid,
    output logic        frame_done,
    output logic [31:0] nb_pixels,
    output logic        bit_err,
    output logic        busy
);

    localparam int TCLK = 1000 / FCLK;
    localparam int CMIN = TMIN / TCLK;
    localparam int CTHR = TTHR / TCLK;
    localparam int CMAX = TMAX / TCLK;
    localparam int CRST = TRST / TCLK;
    localparam int CW   = $clog2(CRST) + 1;

    localparam logic [CW-1:0] CMIN_C   = CW'(CMIN);
    localparam logic [CW-1:0] CTHR_C   = CW'(CTHR);
    localparam logic [CW-1:0] CMAX_C   = CW'(CMAX);
    localparam logic [CW-1:0] CRST_C   = CW'(CRST);
    localparam logic [CW-1:0] CRST_END = CW'(CRST - 1);

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    state_t        state;
    logic          din_m;
    logic          din_s;
    logic          din_d;
    logic          rise;
    logic          fall;
    logic [CW-1:0] cnt;
    logic [CW-1:0] hi_w;
    logic          hi_bit;
    logic          hi_err;
    logic          cnt_end;
    logic [23:0]   word;
    logic [23:0]   word_nxt;
    logic [4:0]    bit_cnt;
    logic [31:0]   pix_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_m <= 1'b0;
            din_s <= 1'b0;
            din_d <= 1'b0;
        end else begin
            din_m <= din;
            din_s <= din_m;
            din_d <= din_s;
        end
    end

    assign rise = din_s & ~din_d;
    assign fall = ~din_s & din_d;

    // cnt lags the high width by one cycle (cleared on the rise cycle itself), so width = cnt + 1
    assign hi_w     = cnt + 1'b1;
    assign hi_bit   = (hi_w >= CTHR_C);
    assign hi_err   = fall ? ((hi_w < CMIN_C) || (hi_w >= CMAX_C)) : (hi_w >= CMAX_C);
    assign cnt_end  = (cnt >= CRST_END);
    assign word_nxt = {word[22:0], hi_bit};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SYNC;
            cnt         <= '0;
            word        <= '0;
            bit_cnt     <= '0;
            pix_cnt     <= '0;
            pixel       <= '0;
            pixel_idx   <= '0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            nb_pixels   <= '0;
            bit_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            bit_err     <= 1'b0;

            if (rise || fall) begin
                cnt <= '0;
            end else if (cnt != CRST_C) begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                SYNC: begin
                    if (din_s) begin
                        cnt <= '0;
                    end else if (cnt_end) begin
                        state <= IDLE;
                    end
                end

                IDLE: begin
                    if (rise) begin
                        state   <= HIGH;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        pix_cnt <= '0;
                    end
                end

                HIGH: begin
                    if (hi_err) begin
                        bit_err <= 1'b1;
                        busy    <= 1'b0;
                        state   <= SYNC;
                    end else if (fall) begin
                        word  <= word_nxt;
                        state <= LOW;
                        if (bit_cnt == 5'd23) begin
                            pixel       <= word_nxt;
                            pixel_idx   <= pix_cnt;
                            pixel_valid <= (pix_cnt < 32'(NB_LEDS));
                            pix_cnt     <= pix_cnt + 32'd1;
                            bit_cnt     <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end

                LOW: begin
                    if (rise) begin
                        state <= HIGH;
                    end else if (cnt_end) begin
                        // latch gap: a partially assembled word is dropped and flagged
                        frame_done <= 1'b1;
                        nb_pixels  <= pix_cnt;
                        busy       <= 1'b0;
                        bit_err    <= (bit_cnt != 5'd0);
                        state      <= IDLE;
                    end
                end

                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812b_rx.sv
// Directed bench for ws2812b_rx at default parameters (CMIN 15, CTHR 62, CMAX 120, CRST 5000 cycles).
module tb_ws2812b_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        din;
    logic [23:0] pixel;
    logic [31:0] pixel_idx;
    logic        pixel_valid;
    logic        frame_done;
    logic [31:0] nb_pixels;
    logic        bit_err;
    logic        busy;

    always #5 clk = ~clk;

    ws2812b_rx dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .pixel      (pixel),
        .pixel_idx  (pixel_idx),
        .pixel_valid(pixel_valid),
        .frame_done (frame_done),
        .nb_pixels  (nb_pixels),
        .bit_err    (bit_err),
        .busy       (busy)
    );

    typedef struct {
        int   nw;
        int   off;
        logic fast;
        int   exp_valid;
        int   exp_nb;
    } fvec_t;

    typedef struct {
        int   hi;
        int   lo;
        logic b;
    } wvec_t;

    int n_chk  = 0;
    int n_pass = 0;

    logic [23:0] pv_pix[$];
    logic [31:0] pv_idx[$];
    int          fd_cnt = 0;
    int          be_cnt = 0;
    logic [31:0] fd_nb  = '0;

    always @(negedge clk) begin
        if (pixel_valid) begin
            pv_pix.push_back(pixel);
            pv_idx.push_back(pixel_idx);
        end
        if (frame_done) begin
            fd_cnt++;
            fd_nb = nb_pixels;
        end
        if (bit_err) be_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // all drive tasks start and end on a falling clock edge
    task automatic pulse(input int hi, input int lo);
        din = 1'b1;
        repeat (hi) @(negedge clk);
        din = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic fast);
        if (fast) begin
            if (b) pulse(70, 20);
            else   pulse(20, 30);
        end else begin
            if (b) pulse(85, 40);
            else   pulse(40, 85);
        end
    endtask

    task automatic send_word(input logic [23:0] w, input logic fast);
        for (int i = 23; i >= 0; i--) send_bit(w[i], fast);
    endtask

    task automatic gap(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        fvec_t       fv [3];
        wvec_t       wv [8];
        logic [23:0] wl [13];
        logic [23:0] expw;
        logic [23:0] tmp;
        int          pv0, fd0, be0, lat, errk, fk;
        logic        fe;
        logic [31:0] nbv;

        wl = '{24'hFF0000,
               24'hFF0000, 24'h00FF00, 24'hFFFFFF, 24'h00FF00, 24'h00FF00,
               24'h123456, 24'hABCDEF, 24'h0F0F0F, 24'h800001, 24'h000000,
               24'h7E7E7E, 24'hC0FFEE};
        fv[0] = '{nw: 1, off: 0, fast: 1'b0, exp_valid: 1, exp_nb: 1};
        fv[1] = '{nw: 5, off: 1, fast: 1'b1, exp_valid: 5, exp_nb: 5};
        fv[2] = '{nw: 7, off: 6, fast: 1'b1, exp_valid: 5, exp_nb: 7};
        wv[0] = '{hi: 62,  lo: 40, b: 1'b1};
        wv[1] = '{hi: 61,  lo: 40, b: 1'b0};
        wv[2] = '{hi: 119, lo: 30, b: 1'b1};
        wv[3] = '{hi: 15,  lo: 50, b: 1'b0};
        wv[4] = '{hi: 85,  lo: 40, b: 1'b1};
        wv[5] = '{hi: 40,  lo: 85, b: 1'b0};
        wv[6] = '{hi: 85,  lo: 40, b: 1'b1};
        wv[7] = '{hi: 85,  lo: 40, b: 1'b1};

        rst = 1'b1;
        din = 1'b0;
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst pixel",       64'(pixel),       64'h0);
        check("rst pixel_idx",   64'(pixel_idx),   64'h0);
        check("rst pixel_valid", 64'(pixel_valid), 64'h0);
        check("rst frame_done",  64'(frame_done),  64'h0);
        check("rst nb_pixels",   64'(nb_pixels),   64'h0);
        check("rst bit_err",     64'(bit_err),     64'h0);
        check("rst busy",        64'(busy),        64'h0);
        rst = 1'b1;
        gap(5010);

        // frame table: 1 pixel, 5 pixels, 7 pixels with only NB_LEDS reported
        for (int v = 0; v < 3; v++) begin
            pv0 = pv_pix.size();
            fd0 = fd_cnt;
            be0 = be_cnt;
            for (int w = 0; w < fv[v].nw; w++) send_word(wl[fv[v].off + w], fv[v].fast);
            check($sformatf("v%0d busy mid", v), 64'(busy), 64'h1);
            gap(5010);
            check($sformatf("v%0d pv count", v), 64'(pv_pix.size() - pv0), 64'(fv[v].exp_valid));
            for (int i = 0; i < fv[v].exp_valid && pv0 + i < pv_pix.size(); i++) begin
                check($sformatf("v%0d pixel%0d", v, i), 64'(pv_pix[pv0 + i]), 64'(wl[fv[v].off + i]));
                check($sformatf("v%0d idx%0d", v, i),   64'(pv_idx[pv0 + i]), 64'(i));
            end
            check($sformatf("v%0d fd count", v),  64'(fd_cnt - fd0), 64'h1);
            check($sformatf("v%0d nb_pixels", v), 64'(fd_nb),        64'(fv[v].exp_nb));
            check($sformatf("v%0d bit_err", v),   64'(be_cnt - be0), 64'h0);
            check($sformatf("v%0d busy end", v),  64'(busy),         64'h0);
        end

        // async reset mid-pixel, then data without a preceding gap is ignored
        pv0 = pv_pix.size();
        fd0 = fd_cnt;
        be0 = be_cnt;
        tmp = 24'h3C5A96;
        for (int i = 23; i >= 19; i--) send_bit(tmp[i], 1'b1);
        din = 1'b1;
        repeat (10) @(negedge clk);
        check("pre-rst busy",  64'(busy),      64'h1);
        check("pre-rst pixel", 64'(pixel),     64'hC0FFEE);
        check("pre-rst idx",   64'(pixel_idx), 64'h6);
        #2 rst = 1'b0;
        #1;
        check("async rst pixel",     64'(pixel),     64'h0);
        check("async rst pixel_idx", 64'(pixel_idx), 64'h0);
        check("async rst nb_pixels", 64'(nb_pixels), 64'h0);
        check("async rst busy",      64'(busy),      64'h0);
        @(negedge clk);
        rst = 1'b1;
        send_word(24'h5A5A5A, 1'b1);
        gap(5010);
        check("post-rst pv none", 64'(pv_pix.size() - pv0), 64'h0);
        check("post-rst fd none", 64'(fd_cnt - fd0),        64'h0);
        check("post-rst be none", 64'(be_cnt - be0),        64'h0);
        send_word(24'h00A5C3, 1'b1);
        gap(5010);
        check("post-rst pv count", 64'(pv_pix.size() - pv0), 64'h1);
        if (pv_pix.size() > pv0) check("post-rst pixel", 64'(pv_pix[pv0]), 64'h00A5C3);
        check("post-rst fd count", 64'(fd_cnt - fd0), 64'h1);
        check("post-rst nb",       64'(fd_nb),        64'h1);

        // 14-cycle pulse is too short; following bits are ignored until a full gap
        pv0 = pv_pix.size();
        fd0 = fd_cnt;
        be0 = be_cnt;
        pulse(14, 100);
        check("short be", 64'(be_cnt - be0), 64'h1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check("short busy ignored", 64'(busy), 64'h0);
        gap(5010);
        check("short be total", 64'(be_cnt - be0),        64'h1);
        check("short pv none",  64'(pv_pix.size() - pv0), 64'h0);
        check("short fd none",  64'(fd_cnt - fd0),        64'h0);

        // recovery frame built from boundary pulse widths
        pv0 = pv_pix.size();
        fd0 = fd_cnt;
        be0 = be_cnt;
        expw = '0;
        for (int i = 0; i < 23; i++) begin
            pulse(wv[i % 8].hi, wv[i % 8].lo);
            expw = {expw[22:0], wv[i % 8].b};
        end
        expw = {expw[22:0], wv[7].b};
        din = 1'b1;
        repeat (wv[7].hi) @(negedge clk);
        din = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (pixel_valid && lat == 0) lat = k;
        end
        check("pv latency", 64'(lat), 64'h3);
        gap(5010);
        check("width pv count", 64'(pv_pix.size() - pv0), 64'h1);
        if (pv_pix.size() > pv0) check("width pixel", 64'(pv_pix[pv0]), 64'(expw));
        check("width fd count", 64'(fd_cnt - fd0), 64'h1);
        check("width be none",  64'(be_cnt - be0), 64'h0);

        // 200-cycle high: error must fire once the width hits 120, line still high
        pv0 = pv_pix.size();
        fd0 = fd_cnt;
        be0 = be_cnt;
        din = 1'b1;
        errk = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (bit_err && errk == 0) errk = k;
        end
        check("long err cycle", 64'(errk), 64'd123);
        gap(5010);
        check("long be total", 64'(be_cnt - be0),        64'h1);
        check("long pv none",  64'(pv_pix.size() - pv0), 64'h0);
        check("long fd none",  64'(fd_cnt - fd0),        64'h0);

        // 12 bits then gap: frame_done and bit_err together, nothing reported
        pv0 = pv_pix.size();
        be0 = be_cnt;
        tmp = 24'hB5A000;
        for (int i = 23; i >= 13; i--) send_bit(tmp[i], 1'b0);
        din = 1'b1;
        repeat (85) @(negedge clk);
        din = 1'b0;
        fk  = 0;
        fe  = 1'b0;
        nbv = 32'hFFFF_FFFF;
        for (int k = 1; k <= 5100; k++) begin
            @(negedge clk);
            if (frame_done) begin
                fk  = k;
                fe  = bit_err;
                nbv = nb_pixels;
                break;
            end
        end
        check("partial fd cycle", 64'(fk),  64'd5003);
        check("partial be same",  64'(fe),  64'h1);
        check("partial nb",       64'(nbv), 64'h0);
        repeat (5) @(negedge clk);
        check("partial pv none",  64'(pv_pix.size() - pv0), 64'h0);
        check("partial be total", 64'(be_cnt - be0),        64'h1);
        check("partial busy",     64'(busy),                64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
